// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the hazard/forwarding controller
// Contents: EX operand-select codes, MUL/DIV scoreboard state encoding,
//           forwarding priority helper.
package hazard_pkg;

  // EX operand mux selects
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // MUL/DIV scoreboard states
  localparam logic [0:0] SB_IDLE = 1'b0;
  localparam logic [0:0] SB_BUSY = 1'b1;

  // MEM result is younger than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit) begin
      return FWD_MEM;
    end else if (wb_hit) begin
      return FWD_WB;
    end else begin
      return FWD_REG;
    end
  endfunction

endpackage

// File: rtl/md_scoreboard.sv
// rtl/md_scoreboard.sv - occupancy tracker for the single non-pipelined MUL/DIV unit
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_id_rs1/2, _used       ID-stage sources and their use flags
//   i_id_rd, i_id_regwen    ID-stage destination and write enable
//   i_id_md_valid           ID instruction is MUL/DIV
//   i_md_start              MUL/DIV issues this cycle (decided by the top)
//   o_busy, o_done          unit occupied / result written at end of this cycle
//   o_md_rd                 destination of the outstanding operation
//   o_hazard                ID instruction must wait for the unit (RAW, WAW, structural)
module md_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_regwen,
  input  logic              i_id_md_valid,
  input  logic              i_md_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [REG_AW-1:0] o_md_rd,
  output logic              o_hazard
);

  localparam int CNT_W = $clog2(MD_LAT);
  // The issue cycle is the first of MD_LAT cycles, so BUSY lasts MD_LAT-1
  // cycles and the counter holds the BUSY cycles still to come after this one.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [REG_AW-1:0] r_md_rd;

  logic w_busy;
  logic w_done;
  logic w_active;
  logic w_raw;
  logic w_waw;

  assign w_busy = (r_state == SB_BUSY);
  assign w_done = w_busy && (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SB_IDLE;
      r_cnt   <= '0;
      r_md_rd <= '0;
    end else if (i_md_start) begin
      // Covers both a fresh issue and a back-to-back reissue in the done cycle.
      r_state <= SB_BUSY;
      r_cnt   <= CNT_LOAD;
      r_md_rd <= i_id_rd;
    end else if (w_busy) begin
      if (w_done) begin
        r_state <= SB_IDLE;
      end else begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  // In the done cycle the register file write-through feeds ID, and the unit
  // frees up, so nothing has to wait.
  assign w_active = w_busy && !w_done;
  assign w_raw    = (r_md_rd != '0) &&
                    ((i_id_rs1_used && (i_id_rs1 == r_md_rd)) ||
                     (i_id_rs2_used && (i_id_rs2 == r_md_rd)));
  assign w_waw    = i_id_regwen && (i_id_rd == r_md_rd);

  assign o_hazard = w_active && (w_raw || w_waw || i_id_md_valid);
  assign o_busy   = w_busy;
  assign o_done   = w_done;
  assign o_md_rd  = r_md_rd;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - forwarding, load-use, MUL/DIV and branch-flush control for the 5-stage pipeline
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   id_* / ex_* / mem_* / wb_*        per-stage register addresses and qualifiers
//   ForwardSelA/B                     EX operand select (00 regfile, 01 WB, 10 MEM)
//   stall, bubble                     hold PC/IF-ID, insert NOP into ID-EX
//   flush_ifid, flush_idex            kill younger instructions on a taken branch
//   md_start, md_busy, md_done, md_rd MUL/DIV issue and occupancy status
// Every output reads 0 while rst is high.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_RegWEn,
  input  logic              id_md_valid,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_RegWEn,
  input  logic              ex_is_load,
  input  logic              ex_branch_taken,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_RegWEn,
  input  logic              mem_is_load,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_RegWEn,
  output logic [1:0]        ForwardSelA,
  output logic [1:0]        ForwardSelB,
  output logic              stall,
  output logic              bubble,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              md_start,
  output logic              md_busy,
  output logic              md_done,
  output logic [REG_AW-1:0] md_rd
);

  logic              w_mem_fwd_ok;
  logic              w_wb_fwd_ok;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;
  logic              w_lu;
  logic              w_mh;
  logic              w_stall;
  logic              w_md_start;
  logic              w_md_busy;
  logic              w_md_done;
  logic [REG_AW-1:0] w_md_rd;

  // A load in MEM has no data yet; it is caught by the load-use stall instead.
  assign w_mem_fwd_ok = mem_RegWEn && !mem_is_load && (mem_rd != '0);
  assign w_wb_fwd_ok  = wb_RegWEn && (wb_rd != '0);

  assign w_fwd_a = fwd_sel(w_mem_fwd_ok && (mem_rd == ex_rs1),
                           w_wb_fwd_ok  && (wb_rd  == ex_rs1));
  assign w_fwd_b = fwd_sel(w_mem_fwd_ok && (mem_rd == ex_rs2),
                           w_wb_fwd_ok  && (wb_rd  == ex_rs2));

  assign w_lu = ex_is_load && ex_RegWEn && (ex_rd != '0) &&
                ((id_rs1_used && (id_rs1 == ex_rd)) ||
                 (id_rs2_used && (id_rs2 == ex_rd)));

  md_scoreboard #(
    .REG_AW (REG_AW),
    .MD_LAT (MD_LAT)
  ) u_md_scoreboard (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_rs1_used (id_rs1_used),
    .i_id_rs2_used (id_rs2_used),
    .i_id_rd       (id_rd),
    .i_id_regwen   (id_RegWEn),
    .i_id_md_valid (id_md_valid),
    .i_md_start    (w_md_start),
    .o_busy        (w_md_busy),
    .o_done        (w_md_done),
    .o_md_rd       (w_md_rd),
    .o_hazard      (w_mh)
  );

  // A taken branch kills the ID instruction, so any hazard it had is moot.
  assign w_stall    = (w_lu || w_mh) && !ex_branch_taken;
  // The unit accepts a new op when idle or in the cycle it retires the old one.
  assign w_md_start = !rst && id_md_valid && (!w_md_busy || w_md_done) &&
                      !w_stall && !ex_branch_taken;

  assign ForwardSelA = rst ? FWD_REG : w_fwd_a;
  assign ForwardSelB = rst ? FWD_REG : w_fwd_b;
  assign stall       = !rst && w_stall;
  assign bubble      = !rst && w_stall;
  assign flush_ifid  = !rst && ex_branch_taken;
  assign flush_idex  = !rst && ex_branch_taken;
  assign md_start    = w_md_start;
  assign md_busy     = !rst && w_md_busy;
  assign md_done     = !rst && w_md_done;
  assign md_rd       = rst ? '0 : w_md_rd;

endmodule
